cpu_step_ctrl: RTL



---
 rtl/onboard_pkg.sv | 17 +
 rtl/debounce_sync.sv | 41 ++++
 rtl/cpu_step_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/onboard_pkg.sv
// Shared types and defaults for the MIPS demo board control slice.
// Divider width helper sizes the run-mode counter for the larger period.
package onboard_pkg;

    typedef enum logic [1:0] {IDLE, STEP, RUN} step_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int FAST_DIV_DEF        = 62_500_000;
    localparam int SLOW_DIV_DEF        = 250_000_000;

    function automatic int DIV_W(input int fast_div, input int slow_div);
        int m;
        m = (fast_div > slow_div) ? fast_div : slow_div;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; the level only
// follows the input once it has disagreed for DEBOUNCE_CYCLES straight cycles.
module debounce_sync
    import onboard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_d};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == TC) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: free-run at one of two rates or single-step
// from a debounced push-button, all in the CLK100MHZ domain.
module cpu_step_ctrl
    import onboard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FAST_DIV        = FAST_DIV_DEF,
    parameter int SLOW_DIV        = SLOW_DIV_DEF,
    parameter int CNT_W           = 16
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_en,
    input  logic             quick,
    output logic             cpu_ce,
    output logic             running,
    output logic             btn_level,
    output logic [CNT_W-1:0] step_count
);

    localparam int DW = DIV_W(FAST_DIV, SLOW_DIV);
    localparam logic [DW-1:0] FAST_TC = DW'(FAST_DIV - 1);
    localparam logic [DW-1:0] SLOW_TC = DW'(SLOW_DIV - 1);

    logic [1:0]       r_run_sync;
    logic [1:0]       r_quick_sync;
    logic             r_quick_q;
    logic             r_level_q;
    step_state_t      r_state;
    step_state_t      w_state_nxt;
    logic [DW-1:0]    r_div;
    logic [DW-1:0]    w_div_nxt;
    logic             r_ce;
    logic             w_ce_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic          w_btn_level;
    logic          w_s_run;
    logic          w_s_quick;
    logic          w_quick_chg;
    logic          w_step_req;
    logic [DW-1:0] w_tc;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (CLK100MHZ),
        .rst     (reset),
        .i_d     (step_btn),
        .o_level (w_btn_level)
    );

    assign w_s_run     = r_run_sync[1];
    assign w_s_quick   = r_quick_sync[1];
    assign w_quick_chg = w_s_quick ^ r_quick_q;
    assign w_step_req  = w_btn_level & ~r_level_q;
    assign w_tc        = w_s_quick ? FAST_TC : SLOW_TC;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_run_sync   <= '0;
            r_quick_sync <= '0;
            r_quick_q    <= 1'b0;
            r_level_q    <= 1'b0;
            r_state      <= IDLE;
            r_div        <= '0;
            r_ce         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_run_sync   <= {r_run_sync[0], run_en};
            r_quick_sync <= {r_quick_sync[0], quick};
            r_quick_q    <= w_s_quick;
            r_level_q    <= w_btn_level;
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_ce         <= w_ce_nxt;
            if (r_ce) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // IDLE: wait for run/step | STEP: one-shot enable | RUN: divided enable.
    // Leaving RUN or a rate change both outrank a coinciding terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_ce_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_nxt = '0;
                if (w_s_run) begin
                    w_state_nxt = RUN;
                end else if (w_step_req) begin
                    w_state_nxt = STEP;
                    w_ce_nxt    = 1'b1;
                end
            end
            STEP: begin
                w_state_nxt = IDLE;
            end
            RUN: begin
                if (!w_s_run) begin
                    w_state_nxt = IDLE;
                    w_div_nxt   = '0;
                end else if (w_quick_chg) begin
                    w_div_nxt = '0;
                end else if (r_div == w_tc) begin
                    w_div_nxt = '0;
                    w_ce_nxt  = 1'b1;
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_div_nxt   = '0;
            end
        endcase
    end

    assign cpu_ce     = r_ce;
    assign running    = (r_state == RUN);
    assign btn_level  = w_btn_level;
    assign step_count = r_cnt;

endmodule
